// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done request bus between the instruction decoder and alu_seq
//   master (decoder): drives start, A, X, Opsel, A_inv, X_inv, OP_inv, Carrybit
//                     and receives Z, Flags, busy, done
//   slave  (alu_seq): the reverse directions
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] X;
  logic [2:0]       Opsel;
  logic             A_inv;
  logic             X_inv;
  logic             OP_inv;
  logic             Carrybit;
  logic [WIDTH-1:0] Z;
  logic [7:0]       Flags;
  logic             busy;
  logic             done;
  modport master (
    output start, A, X, Opsel, A_inv, X_inv, OP_inv, Carrybit,
    input  Z, Flags, busy, done
  );
  modport slave (
    input  start, A, X, Opsel, A_inv, X_inv, OP_inv, Carrybit,
    output Z, Flags, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/add ops and iterative shifts and multiply
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   alu_seq_if.slave: start/operands/controls in; Z, Flags {3'b0,P,V,N,Z,C}, busy, done out
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic    clk,
  input logic    rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_p, x_p, r1, acc, hi, mcand, step_lo, step_hi, res_r, z_fin, z_q;
  logic [WIDTH:0]   add, sum;
  logic [SHW-1:0]   s;
  logic [SHW:0]     cnt;
  logic [2:0]       op;
  logic [7:0]       flags_q;
  logic             op_inv, accept, iter_op, last, wr, c1, v1, step_c, res_c, res_v, res_inv, done_q;
  always_comb begin
    a_p     = bus.A_inv ? ~bus.A : bus.A;
    x_p     = bus.X_inv ? ~bus.X : bus.X;
    s       = x_p[SHW-1:0];
    accept  = bus.start && state == IDLE;
    iter_op = bus.Opsel == 3'd6 || (bus.Opsel inside {3'd3, 3'd4, 3'd5} && s != '0);
    add     = {1'b0, a_p} + {1'b0, x_p} + {{WIDTH{1'b0}}, bus.Carrybit};
    r1      = a_p;
    c1      = 1'b0;
    v1      = 1'b0;
    case (bus.Opsel)
      3'd0: r1 = a_p & x_p;
      3'd1: r1 = a_p ^ x_p;
      3'd2: begin
        {c1, r1} = add;
        v1 = a_p[WIDTH-1] == x_p[WIDTH-1] && add[WIDTH-1] != a_p[WIDTH-1];
      end
      default: r1 = a_p;
    endcase
  end
  // One iteration: a one-bit shift of acc, or a shift-add multiply step where
  // acc holds the multiplier (consumed LSB first) and the product grows into {hi, acc}.
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    step_lo = {sum[0], acc[WIDTH-1:1]};
    step_hi = sum[WIDTH:1];
    step_c  = 1'b0;
    case (op)
      3'd3: {step_lo, step_c} = {1'b0, acc};
      3'd4: {step_c, step_lo} = {acc, 1'b0};
      3'd5: {step_lo, step_c} = {acc[WIDTH-1], acc};
      default: step_c = 1'b0;
    endcase
  end
  always_comb begin
    last     = cnt == (SHW+1)'(1);
    wr       = (accept && !iter_op) || (state == EXEC && last);
    state_nx = state == IDLE ? ((accept && iter_op) ? EXEC : IDLE) : (last ? IDLE : EXEC);
    res_r    = state == EXEC ? step_lo : r1;
    res_c    = state == EXEC ? (op == 3'd6 ? |step_hi : step_c) : c1;
    res_v    = state == EXEC ? 1'b0 : v1;
    res_inv  = state == EXEC ? op_inv : bus.OP_inv;
    z_fin    = res_inv ? ~res_r : res_r;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      acc     <= '0;
      hi      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      op      <= '0;
      op_inv  <= 1'b0;
    end else begin
      done_q <= wr;
      if (wr) begin
        z_q     <= z_fin;
        flags_q <= {3'b000, ^z_fin, res_v, z_fin[WIDTH-1], z_fin == '0, res_c};
      end
      if (accept) begin
        acc    <= bus.Opsel == 3'd6 ? x_p : a_p;
        mcand  <= a_p;
        hi     <= '0;
        cnt    <= bus.Opsel == 3'd6 ? (SHW+1)'(WIDTH) : {1'b0, s};
        op     <= bus.Opsel;
        op_inv <= bus.OP_inv;
      end else if (state == EXEC) begin
        acc <= step_lo;
        hi  <= step_hi;
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign bus.Z     = z_q;
  assign bus.Flags = flags_q;
  assign bus.done  = done_q;
  assign bus.busy  = state == EXEC;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (WIDTH=8)
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  alu_seq_if #(.WIDTH(8)) bus ();
  alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic go(input logic [2:0] op, input logic [7:0] a, input logic [7:0] x,
                    input logic ai, input logic xi, input logic oi, input logic cb);
    bus.Opsel = op; bus.A = a; bus.X = x;
    bus.A_inv = ai; bus.X_inv = xi; bus.OP_inv = oi; bus.Carrybit = cb;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] x,
                     input logic ai, input logic xi, input logic oi, input logic cb, input logic poke,
                     input int lat_e, input logic [7:0] z_e, input logic [7:0] f_e);
    int lat;
    go(op, a, x, ai, xi, oi, cb);
    lat = 1;
    while (!bus.done && lat < 40) begin
      chk({tag, " busy"}, bus.busy, 1);
      bus.A = 8'($urandom); bus.X = 8'($urandom); bus.Opsel = 3'($urandom);
      bus.A_inv = 1'($urandom); bus.X_inv = 1'($urandom); bus.OP_inv = 1'($urandom);
      bus.Carrybit = 1'($urandom);
      bus.start = poke && lat == 1;
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, lat, lat_e);
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " busy_end"}, bus.busy, 0);
    chk({tag, " Z"}, bus.Z, z_e);
    chk({tag, " Flags"}, bus.Flags, f_e);
  endtask
  initial begin
    int seen;
    bus.start = 1'b0; bus.A = '0; bus.X = '0; bus.Opsel = '0;
    bus.A_inv = 1'b0; bus.X_inv = 1'b0; bus.OP_inv = 1'b0; bus.Carrybit = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst Z", bus.Z, 0);
    chk("rst Flags", bus.Flags, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run("and",     3'd0, 8'hAA, 8'h33, 0, 0, 0, 0, 0, 1, 8'h22, 8'h00);
    run("nand",    3'd0, 8'hAA, 8'h33, 0, 0, 1, 0, 0, 1, 8'hDD, 8'h04);
    run("sub",     3'd2, 8'hAA, 8'h33, 0, 1, 0, 1, 0, 1, 8'h77, 8'h09);
    run("add_c",   3'd2, 8'hF0, 8'h10, 0, 0, 0, 0, 0, 1, 8'h00, 8'h03);
    run("pass",    3'd7, 8'h5A, 8'h00, 1, 0, 0, 0, 0, 1, 8'hA5, 8'h04);
    run("shl",     3'd4, 8'hAA, 8'h03, 0, 0, 0, 0, 1, 4, 8'h50, 8'h01);
    @(negedge clk);
    chk("shl no_queue done", bus.done, 0);
    chk("shl no_queue busy", bus.busy, 0);
    chk("shl hold Z", bus.Z, 8'h50);
    run("asr",     3'd5, 8'h80, 8'h07, 0, 0, 0, 0, 0, 8, 8'hFF, 8'h04);
    run("shr0",    3'd3, 8'h80, 8'h00, 0, 0, 0, 0, 0, 1, 8'h80, 8'h14);
    run("shr",     3'd3, 8'hF1, 8'h02, 0, 0, 0, 0, 0, 3, 8'h3C, 8'h00);
    run("mul",     3'd6, 8'h0F, 8'h13, 0, 0, 0, 0, 0, 9, 8'h1D, 8'h01);
    run("mul_lo",  3'd6, 8'h07, 8'h03, 0, 0, 0, 0, 0, 9, 8'h15, 8'h10);
    @(negedge clk);
    chk("mul hold done", bus.done, 0);
    chk("mul hold Z", bus.Z, 8'h15);
    go(3'd6, 8'h0F, 8'h13, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort Z", bus.Z, 0);
    chk("abort Flags", bus.Flags, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort no_done", seen, 0);
    run("xor",     3'd1, 8'hAA, 8'h33, 0, 0, 0, 0, 0, 1, 8'h99, 8'h04);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
